writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `in_valid`, input, 1 bit: upstream (memory stage) presents an instruction.
REQ-004 SHALL have `in_ready`, output, 1 bit: unit accepts; transfer occurs when `in_valid` and `in_ready` are both 1.
REQ-005 SHALL have `in_reg_write`, input, 1 bit: instruction writes a destination register.
REQ-006 SHALL have `in_rd`, input, 5 bits: destination register index.
REQ-007 SHALL have `in_result`, input, 32 bits: ALU or link result for non-loads.
REQ-008 SHALL have `in_is_load`, input, 1 bit: instruction is a load.
REQ-009 SHALL have `in_funct3`, input, 3 bits: load size/sign code.
REQ-010 SHALL have `in_addr_lo`, input, 2 bits: load byte offset.
REQ-011 SHALL have `mem_rvalid`, input, 1 bit: data memory read response valid.
REQ-012 SHALL have `mem_rdata`, input, 32 bits: raw aligned memory word.
REQ-013 SHALL have `rf_we`, output, 1 bit: register-file write enable.
REQ-014 SHALL have `rf_addr`, output, 5 bits: register-file write index.
REQ-015 SHALL have `rf_wdata`, output, 32 bits: register-file write data.
REQ-016 SHALL have `load_err`, output, 1 bit: sticky error flag.
REQ-017 SHALL have `retire_count`, output, 32 bits: count of retired instructions.

Function
REQ-018 SHALL implement an FSM with two states, IDLE and LOAD_WAIT; `in_ready` is 1 exactly when the state is IDLE.
REQ-019 On a non-load accepted in cycle N, SHALL drive `rf_we`/`rf_addr`/`rf_wdata` from registers in cycle N+1; rf_wdata = in_result; back-to-back acceptance every cycle is supported.
REQ-020 On a load accepted, SHALL latch rd, reg_write, funct3 and addr_lo, and move to LOAD_WAIT.
REQ-021 In LOAD_WAIT, the cycle `mem_rvalid` = 1 SHALL return the FSM to IDLE, and the extended data SHALL appear on the write port the following cycle.
REQ-022 Load extension, selected by funct3, SHALL be:
- 000 LB: sign-extend byte[addr_lo].
- 001 LH: sign-extend half[addr_lo[1]].
- 010 LW: full word.
- 100 LBU: zero-extend byte[addr_lo].
- 101 LHU: zero-extend half[addr_lo[1]].
REQ-023 Misalignment (LH/LHU with addr_lo[0] = 1; LW with addr_lo ≠ 0) or an illegal funct3 SHALL suppress the write and set `load_err`.
REQ-024 `rf_we` SHALL be 0 whenever rd = 0 or reg_write = 0; `rf_addr` and `rf_wdata` are don't-care when `rf_we` = 0.
REQ-025 `mem_rvalid` in IDLE SHALL be ignored for writes and SHALL set `load_err`.
REQ-026 `load_err` SHALL stay set until reset.
REQ-027 `retire_count` SHALL increment by 1, wrapping modulo 2^32, in the cycle a completion is presented:
- non-load: cycle N+1;
- load: the cycle after rvalid.
This includes suppressed writes (rd = 0, reg_write = 0, or an erroring load).
REQ-028 `rf_we` SHALL be a single-cycle pulse per instruction; it never holds across cycles without a new completion.

Reset
REQ-029 While `rst` = 1 at a clock edge: state ← IDLE, rf_we ← 0, rf_addr ← 0, rf_wdata ← 0, load_err ← 0, retire_count ← 0; `in_ready` reads 1 in the cycle after reset.
REQ-030 Reset during LOAD_WAIT SHALL discard the pending load without writing; a later stale `mem_rvalid` is treated per REQ-025.
REQ-031 Reset SHALL override a simultaneous acceptance or `mem_rvalid`.

Structure
REQ-032 A shared package wb_pkg SHALL hold the FSM state enum and the load funct3 encodings (LB, LH, LW, LBU, LHU).
REQ-033 Byte/halfword selection and extension SHALL live in one combinational sub-module, load_extend (inputs: funct3, addr_lo, rdata; outputs: data, misaligned/illegal).
REQ-034 All outputs except `in_ready` SHALL be registered.

Verification
REQ-035 Non-load back-to-back: three non-loads accepted in cycles 1–3 (rd = 5, result = 0x11; rd = 6, 0x22; rd = 7, 0x33) -> `rf_we` pulses in cycles 2–4 with matching addr/data; retire_count = 3.
REQ-036 Load with wait: LB, addr_lo = 3, mem_rvalid 4 cycles later with rdata = 0x80FF_1234 -> in_ready = 0 while waiting; write rd of 0xFFFF_FF80 one cycle after rvalid.
REQ-037 Load variants: LHU, addr_lo = 2, rdata = 0x9ABC_1234 -> 0x0000_9ABC; LH same -> 0xFFFF_9ABC; LW addr_lo = 0 -> 0x9ABC_1234.
REQ-038 Errors: LW addr_lo = 1 -> no write, load_err = 1, retire_count += 1; then rvalid in IDLE -> still no write, load_err stays 1.
REQ-039 rd = 0: non-load rd = 0, result = 0xDEAD_BEEF -> rf_we stays 0, retire_count += 1.
REQ-040 Reset mid-load: load accepted, rst asserted before rvalid, rvalid arrives after reset -> no write, load_err = 1, retire_count = 0; retire_count wraps from 0xFFFF_FFFF to 0 when preloaded via forced state.

Source files
------------

// File: rtl/wb_pkg.sv
// Writeback unit shared types: FSM state and load size/sign encodings.
package wb_pkg;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_unit_if.sv
// Memory-stage handshake, data-memory response and register-file write port.
interface writeback_unit_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        load_err;
  logic [31:0] retire_count;

  modport slave (
    input  in_valid, in_reg_write, in_rd,
    input  in_result, in_is_load, in_funct3,
    input  in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_addr,
    output rf_wdata, load_err, retire_count
  );

  modport master (
    output in_valid, in_reg_write, in_rd,
    output in_result, in_is_load, in_funct3,
    output in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_addr,
    input  rf_wdata, load_err, retire_count
  );

endinterface

// File: rtl/writeback_unit_load_extend.sv
// Byte/halfword lane select and sign/zero extension of a load word.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_s = rdata_i[7:0];
      2'd1: byte_s = rdata_i[15:8];
      2'd2: byte_s = rdata_i[23:16];
      2'd3: byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
  end

  assign half_s = addr_lo_i[1] ? rdata_i[31:16]
                               : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    err_o  = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU: data_o = {24'd0, byte_s};
      F3_LH: begin
        data_o = {{16{half_s[15]}}, half_s};
        err_o  = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o = {16'd0, half_s};
        err_o  = addr_lo_i[0];
      end
      F3_LW:  err_o = (addr_lo_i != 2'd0);
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registered RF write port, load wait FSM, retire counter.
module writeback_unit
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  writeback_unit_if.slave bus
);

  wb_state_e   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ext_data;
  logic        ext_err;

  load_extend u_ext (
    .funct3_i  (f3_q),
    .addr_lo_i (alo_q),
    .rdata_i   (bus.mem_rdata),
    .data_o    (ext_data),
    .err_o     (ext_err)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A response with no load outstanding is a protocol error
        if (bus.mem_rvalid) err_d = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_is_load) begin
            rd_d    = bus.in_rd;
            rw_d    = bus.in_reg_write;
            f3_d    = bus.in_funct3;
            alo_d   = bus.in_addr_lo;
            state_d = LOAD_WAIT;
          end else begin
            we_d    = bus.in_reg_write && (bus.in_rd != 5'd0);
            addr_d  = bus.in_rd;
            wdata_d = bus.in_result;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      LOAD_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          we_d    = rw_q && (rd_q != 5'd0) && !ext_err;
          addr_d  = rd_q;
          wdata_d = ext_data;
          err_d   = err_q | ext_err;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      f3_q    <= 3'd0;
      alo_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.rf_we        = we_q;
  assign bus.rf_addr      = addr_q;
  assign bus.rf_wdata     = wdata_q;
  assign bus.load_err     = err_q;
  assign bus.retire_count = cnt_q;

endmodule
